// File: rtl/memory_layer.sv
// memory_layer: learns (vector, class) pairs into a small node memory.
// Each accepted pair is compared against every stored node in one cycle;
// a match bumps that node's saturating hit counter, otherwise the pair is
// appended while space remains. Pairs with a zero vector or zero class are
// discarded. learning_done freezes the memory until the next reset.
module memory_layer #(
  parameter int unsigned VECTOR_LEN = 4,
  parameter int unsigned MAX_NODES  = 16
) (
  input  logic                               clk,
  input  logic [VECTOR_LEN*8-1:0]            x,
  input  logic [31:0]                        c,
  input  logic                               reset,
  input  logic                               learning_done,
  input  logic                               learning_recall,
  output logic                               ready_wait,
  output logic [$clog2(MAX_NODES+1)-1:0]     node_count,
  output logic                               mem_full
);

  localparam int unsigned VEC_W = VECTOR_LEN * 8;
  localparam int unsigned CNT_W = $clog2(MAX_NODES + 1);
  localparam int unsigned IDX_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

  localparam logic LEARNING = 1'b0;
  localparam logic READY    = 1'b1;
  localparam logic IDLE     = 1'b0;

  typedef enum logic [1:0] {
    READY_S,
    UPDATE_S,
    DONE_S
  } state_e;

  state_e state_q, state_d;

  // Node storage, readable hierarchically by the recall block.
  logic [VEC_W-1:0] node_mem  [MAX_NODES];
  logic [31:0]      class_mem [MAX_NODES];
  logic [7:0]       hit_cnt   [MAX_NODES];
  logic [MAX_NODES-1:0] valid_q;

  logic [VEC_W-1:0] x_q;
  logic [31:0]      c_q;
  logic [CNT_W-1:0] node_count_q;
  logic             mem_full_q;

  logic             load;
  logic             discard;
  logic             hit_found;
  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [CNT_W-1:0] cnt_inc;
  logic             do_hit;
  logic             do_new;

  assign node_count = node_count_q;
  assign mem_full   = mem_full_q;
  assign discard    = (x_q == '0) || (c_q == '0);
  assign wr_idx     = node_count_q[IDX_W-1:0];
  assign cnt_inc    = node_count_q + 1'b1;
  assign do_hit     = (state_q == UPDATE_S) && !discard && hit_found;
  assign do_new     = (state_q == UPDATE_S) && !discard && !hit_found && !mem_full_q;

  // Parallel compare of the registered pair against every valid node.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int unsigned i = 0; i < MAX_NODES; i++) begin
      if (!hit_found && valid_q[i] && (node_mem[i] == x_q) && (class_mem[i] == c_q)) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    ready_wait = IDLE;
    case (state_q)
      READY_S: begin
        ready_wait = READY;
        if (learning_done) begin
          state_d = DONE_S;
        end else if (learning_recall == LEARNING) begin
          state_d = UPDATE_S;
          load    = 1'b1;
        end
      end
      UPDATE_S: state_d = READY_S;
      DONE_S:   state_d = DONE_S;
      default:  state_d = READY_S;
    endcase
  end

  // State, counters, valid flags and hit counters (reset has priority).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= READY_S;
      node_count_q <= '0;
      mem_full_q   <= 1'b0;
      valid_q      <= '0;
      for (int unsigned i = 0; i < MAX_NODES; i++) begin
        hit_cnt[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (do_hit && (hit_cnt[hit_idx] != 8'hFF)) begin
        hit_cnt[hit_idx] <= hit_cnt[hit_idx] + 8'd1;
      end
      if (do_new) begin
        hit_cnt[wr_idx] <= 8'd1;
        valid_q[wr_idx] <= 1'b1;
        node_count_q    <= cnt_inc;
        mem_full_q      <= (cnt_inc == CNT_W'(MAX_NODES));
      end
    end
  end

  // Input capture and node payload writes; payload needs no reset because
  // valid_q gates every compare.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (load) begin
        x_q <= x;
        c_q <= c;
      end
      if (do_new) begin
        node_mem[wr_idx]  <= x_q;
        class_mem[wr_idx] <= c_q;
      end
    end
  end

endmodule

// File: tb/tb_memory_layer.sv
// Directed bench for memory_layer with hand-computed expectations.
module tb_memory_layer;

  logic        clk = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] c = '0;
  logic        reset = 1'b1;
  logic        learning_done = 1'b0;
  logic        learning_recall = 1'b1;
  logic        ready_wait;
  logic [4:0]  node_count;
  logic        mem_full;

  int vectors = 0;
  int miscompares = 0;

  memory_layer #(.VECTOR_LEN(4), .MAX_NODES(16)) dut (
    .clk(clk),
    .x(x),
    .c(c),
    .reset(reset),
    .learning_done(learning_done),
    .learning_recall(learning_recall),
    .ready_wait(ready_wait),
    .node_count(node_count),
    .mem_full(mem_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    learning_done = 1'b0;
    learning_recall = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Present one pair for a single accept edge, then park in RECALL.
  task automatic learn(input logic [31:0] xv, input logic [31:0] cv);
    x = xv;
    c = cv;
    learning_done = 1'b0;
    learning_recall = 1'b0;
    tick();
    learning_recall = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    do_reset();
    chk("rst_ready", 32'(ready_wait), 32'd1);
    chk("rst_count", 32'(node_count), 32'd0);
    chk("rst_full", 32'(mem_full), 32'd0);

    // First learn with latency check
    x = 32'h0000_000F; c = 32'd1; learning_recall = 1'b0;
    tick();
    learning_recall = 1'b1;
    chk("lat_idle", 32'(ready_wait), 32'd0);
    chk("lat_count_pending", 32'(node_count), 32'd0);
    tick();
    chk("lat_ready", 32'(ready_wait), 32'd1);
    chk("s1_count", 32'(node_count), 32'd1);
    chk("s1_node0", dut.node_mem[0], 32'h0000_000F);
    chk("s1_class0", dut.class_mem[0], 32'd1);
    chk("s1_hit0", 32'(dut.hit_cnt[0]), 32'd1);

    // Repeated pair counts hits
    do_reset();
    learn(32'hF0F0_F0F0, 32'd2);
    learn(32'hF0F0_F0F0, 32'd2);
    learn(32'hF0F0_F0F0, 32'd2);
    chk("s2_count", 32'(node_count), 32'd1);
    chk("s2_hit0", 32'(dut.hit_cnt[0]), 32'd3);

    // Same vector, different class -> new node
    do_reset();
    learn(32'hAAAA_AAAA, 32'd3);
    learn(32'hAAAA_AAAA, 32'd4);
    chk("s3_count", 32'(node_count), 32'd2);
    chk("s3_class0", dut.class_mem[0], 32'd3);
    chk("s3_class1", dut.class_mem[1], 32'd4);
    chk("s3_node1", dut.node_mem[1], 32'hAAAA_AAAA);

    // Zero vector / zero class discarded
    learn(32'h0, 32'd5);
    learn(32'h1, 32'd0);
    chk("s4_count", 32'(node_count), 32'd2);
    chk("s4_hit2", 32'(dut.hit_cnt[2]), 32'd0);

    // RECALL in READY_S leaves memory alone
    x = 32'h1234_5678; c = 32'd9; learning_recall = 1'b1;
    tick(); tick(); tick();
    chk("recall_ready", 32'(ready_wait), 32'd1);
    chk("recall_count", 32'(node_count), 32'd2);

    // Reset mid-UPDATE_S discards pending pair
    x = 32'h5; c = 32'd5; learning_recall = 1'b0;
    tick();
    chk("midupd_idle", 32'(ready_wait), 32'd0);
    reset = 1'b1; learning_recall = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("midupd_count", 32'(node_count), 32'd0);
    chk("midupd_hit0", 32'(dut.hit_cnt[0]), 32'd0);
    chk("midupd_ready", 32'(ready_wait), 32'd1);

    // Hit counter saturation
    for (int i = 0; i < 256; i++) learn(32'h7, 32'd7);
    chk("sat_hit0", 32'(dut.hit_cnt[0]), 32'd255);
    chk("sat_count", 32'(node_count), 32'd1);

    // Fill memory with 17 distinct pairs
    do_reset();
    for (int i = 1; i <= 15; i++) learn(32'(i), 32'd1);
    chk("fill15_count", 32'(node_count), 32'd15);
    chk("fill15_full", 32'(mem_full), 32'd0);
    learn(32'd16, 32'd1);
    chk("fill16_count", 32'(node_count), 32'd16);
    chk("fill16_full", 32'(mem_full), 32'd1);
    chk("fill16_node15", dut.node_mem[15], 32'd16);
    learn(32'd17, 32'd1);
    chk("fill17_count", 32'(node_count), 32'd16);
    chk("fill17_full", 32'(mem_full), 32'd1);
    chk("fill17_node15", dut.node_mem[15], 32'd16);
    learn(32'd3, 32'd1);
    chk("full_match_hit2", 32'(dut.hit_cnt[2]), 32'd2);
    chk("full_match_count", 32'(node_count), 32'd16);

    // learning_done with RECALL -> DONE_S, frozen
    learning_done = 1'b1; learning_recall = 1'b1;
    tick();
    chk("done_idle", 32'(ready_wait), 32'd0);
    learning_done = 1'b0; learning_recall = 1'b0;
    x = 32'd3; c = 32'd1;
    tick(); tick(); tick(); tick();
    chk("done_still_idle", 32'(ready_wait), 32'd0);
    chk("done_count", 32'(node_count), 32'd16);
    chk("done_hit2", 32'(dut.hit_cnt[2]), 32'd2);
    do_reset();
    chk("post_done_ready", 32'(ready_wait), 32'd1);
    chk("post_done_count", 32'(node_count), 32'd0);
    chk("post_done_full", 32'(mem_full), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
